// File: rtl/emin_scheduler.sv
// Frame sequencer for the emin block: issues i = 0..I-1 in order, checks each j-stream,
// runs a stall watchdog, and shares the single T_bram read port with one external reader.
module emin_scheduler #(
  parameter int I       = 160,
  parameter int TIMEOUT = 256,
  parameter int RD_LAT  = 2,
  localparam int IW     = $clog2(I),
  localparam int WW     = $clog2(TIMEOUT + 1)
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          start_in,
  output logic [IW-1:0] emin_i_out,
  output logic          emin_valid_out,
  input  logic [IW-1:0] emin_T_req_in,
  input  logic          emin_out_valid_in,
  input  logic [IW-1:0] emin_j_in,
  input  logic          ext_req_in,
  input  logic [IW-1:0] ext_addr_in,
  output logic          ext_grant_out,
  output logic          ext_rdata_valid_out,
  output logic [IW-1:0] T_addr_out,
  output logic [IW-1:0] cur_i_out,
  output logic          busy_out,
  output logic          done_out,
  output logic          error_out
);

  typedef enum logic [1:0] {IDLE, ISSUE, RUN, GAP} state_t;

  state_t          state, state_d;
  logic [IW-1:0]   cur_i, cur_i_d;
  logic [IW-1:0]   exp_j, exp_j_d;
  logic [WW-1:0]   wd, wd_d;
  logic            err, err_d;
  logic            busy, busy_d;
  logic            done, done_d;
  logic [RD_LAT-1:0] rd_pipe;
  logic            emin_owns;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state   <= IDLE;
      cur_i   <= '0;
      exp_j   <= '0;
      wd      <= '0;
      err     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_pipe <= '0;
    end else begin
      state   <= state_d;
      cur_i   <= cur_i_d;
      exp_j   <= exp_j_d;
      wd      <= wd_d;
      err     <= err_d;
      busy    <= busy_d;
      done    <= done_d;
      rd_pipe[0] <= ext_grant_out;
      for (int unsigned k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
  end

  always_comb begin
    state_d = state;
    cur_i_d = cur_i;
    exp_j_d = exp_j;
    wd_d    = wd;
    err_d   = err;
    busy_d  = busy;
    done_d  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_in) begin
          cur_i_d = '0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        exp_j_d = '0;
        wd_d    = '0;
        state_d = RUN;
      end
      RUN: begin
        if (emin_out_valid_in) begin
          if (emin_j_in != exp_j) begin
            err_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            exp_j_d = exp_j + IW'(1);
            wd_d    = '0;
            if (emin_j_in == cur_i) state_d = GAP;
          end
        end else if (wd == WW'(TIMEOUT - 1)) begin
          // this idle cycle is the TIMEOUT-th one in a row
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (wd != '1) begin
          wd_d = wd + WW'(1);
        end
      end
      GAP: begin
        if (cur_i == IW'(I - 1)) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cur_i_d = cur_i + IW'(1);
          state_d = ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign emin_owns           = (state == ISSUE) || (state == RUN);
  assign ext_grant_out       = !emin_owns && ext_req_in;
  assign T_addr_out          = emin_owns ? emin_T_req_in : (ext_req_in ? ext_addr_in : '0);
  assign ext_rdata_valid_out = rd_pipe[RD_LAT-1];
  assign emin_valid_out      = (state == ISSUE);
  assign emin_i_out          = cur_i;
  assign cur_i_out           = cur_i;
  assign busy_out            = busy;
  assign done_out            = done;
  assign error_out           = err;

endmodule
